uart_rx_param: RTL and testbench

Parametrised UART receiver. Successor to the fixed 8-bit/parity receiver: configurable data width, oversampling ratio, parity mode and stop-bit count. Adds an input synchroniser, mid-bit majority-vote sampling and false-start rejection. Delivers each frame through a one-entry valid/ready holding register, with parity, framing and overrun reporting.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_sampler.sv | 33 +++
 rtl/uart_rx_param.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// receiver FSM states and the parity check helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Widest supported data word; narrower words are zero-extended.
  localparam int unsigned MaxDataBits = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  function automatic logic parity_error(input int unsigned          mode,
                                        input logic [MaxDataBits-1:0] data,
                                        input logic                 pbit);
    logic x;
    x = (^data) ^ pbit;
    case (mode)
      PAR_EVEN: parity_error = x;
      PAR_ODD:  parity_error = ~x;
      default:  parity_error = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning: two-flop synchroniser, 3-sample history and majority vote.
module uart_rx_sampler (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic sync_o,
  output logic bit_o
);

  logic [1:0] sync_q, sync_d;
  logic [2:0] samp_q, samp_d;

  // Reset to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      samp_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
      samp_q <= samp_d;
    end
  end

  always_comb begin
    sync_d = {sync_q[0], rx_i};
    samp_d = {samp_q[1:0], sync_q[1]};
  end

  assign sync_o = sync_q[1];
  assign bit_o  = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                  (samp_q[1] & samp_q[2]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: bit timing, frame FSM and a one-entry
// valid/ready holding register with parity, framing and overrun reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 2,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 uart_clock,
  input  logic                 rst,
  input  logic                 serial_data,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 par_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 3);

  localparam logic [CntW-1:0] CntHalf     = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntLast     = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] IdxLastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] IdxLastStop = IdxW'(STOP_BITS - 1);

  logic line_sync;
  logic line_bit;

  rx_state_e state_q, state_d;

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;

  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic                   sample_tick;
  logic                   frame_done;
  logic                   frame_ferr;
  logic [MaxDataBits-1:0] data_ext;

  uart_rx_sampler u_sampler (
    .clk_i  (uart_clock),
    .rst_i  (rst),
    .rx_i   (serial_data),
    .sync_o (line_sync),
    .bit_o  (line_bit)
  );

  // Start bit is checked at its middle; every later bit one full period on.
  assign sample_tick = (state_q == StStart) ? (cnt_q == CntHalf) : (cnt_q == CntLast);
  assign frame_done  = (state_q == StStop) && sample_tick && (idx_q == IdxLastStop);
  assign frame_ferr  = ferr_q | ~line_bit;
  assign data_ext    = MaxDataBits'(shift_q);

  // FSM state register
  always_ff @(posedge uart_clock or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!line_sync && armed_q) state_d = StStart;
      end
      StStart: begin
        if (sample_tick) state_d = line_bit ? StIdle : StData;
      end
      StData: begin
        if (sample_tick && (idx_q == IdxLastData)) begin
          state_d = (PARITY != PAR_NONE) ? StParity : StStop;
        end
      end
      StParity: begin
        if (sample_tick) state_d = StStop;
      end
      StStop: begin
        if (frame_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Bit timing, shift register and per-frame error tracking
  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    armed_d = armed_q;

    if ((state_q == StIdle) || ((state_q == StStart) && sample_tick) || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end

    if (state_d != state_q) begin
      idx_d = '0;
    end else if (sample_tick) begin
      idx_d = idx_q + IdxW'(1);
    end

    if (state_q == StIdle) begin
      perr_d = 1'b0;
      ferr_d = 1'b0;
    end

    if (sample_tick) begin
      if (state_q == StData) shift_d = {line_bit, shift_q[DATA_BITS-1:1]};
      if (state_q == StParity) perr_d = parity_error(PARITY, data_ext, line_bit);
      if ((state_q == StStop) && !line_bit) ferr_d = 1'b1;
    end

    // A frame ending on a low line (break) must see the line high again before re-arming.
    if (frame_done && frame_ferr) begin
      armed_d = 1'b0;
    end else if (line_sync) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge uart_clock or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
    end
  end

  // Holding register: a completing frame loads unless the previous word is still unread.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    overrun_d   = 1'b0;

    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_d       = shift_q;
        par_err_d   = perr_q;
        frame_err_d = frame_ferr;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge uart_clock or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign par_err   = par_err_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one odd-parity and one even-parity receiver
// share the serial line; expected values are hand-computed per frame.
module tb_uart_rx_param;

  localparam int unsigned Os = 16;

  logic clk = 1'b0;
  logic rst;
  logic serial;
  logic rdy;

  logic [7:0] o_out, e_out;
  logic       o_vld, o_perr, o_ferr, o_ovr, o_busy;
  logic       e_vld, e_perr, e_ferr, e_ovr, e_busy;

  int nvec = 0;
  int nerr = 0;

  int         ovr_o_n = 0;
  int         ovr_e_n = 0;
  int         got_n   = 0;
  logic [7:0] got [0:15];

  uart_rx_param #(
    .DATA_BITS  (8),
    .OVERSAMPLE (Os),
    .PARITY     (2),
    .STOP_BITS  (1)
  ) u_odd (
    .uart_clock  (clk),
    .rst         (rst),
    .serial_data (serial),
    .out         (o_out),
    .out_valid   (o_vld),
    .out_ready   (rdy),
    .par_err     (o_perr),
    .frame_err   (o_ferr),
    .overrun     (o_ovr),
    .busy        (o_busy)
  );

  uart_rx_param #(
    .DATA_BITS  (8),
    .OVERSAMPLE (Os),
    .PARITY     (1),
    .STOP_BITS  (1)
  ) u_even (
    .uart_clock  (clk),
    .rst         (rst),
    .serial_data (serial),
    .out         (e_out),
    .out_valid   (e_vld),
    .out_ready   (rdy),
    .par_err     (e_perr),
    .frame_err   (e_ferr),
    .overrun     (e_ovr),
    .busy        (e_busy)
  );

  always #5 clk = ~clk;

  // Count overrun pulses and record accepted words (odd receiver).
  always @(negedge clk) begin
    if (o_ovr === 1'b1) ovr_o_n++;
    if (e_ovr === 1'b1) ovr_e_n++;
    if (o_vld === 1'b1 && rdy === 1'b1 && got_n < 16) begin
      got[got_n] = o_out;
      got_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial = b;
    repeat (Os) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic accept();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  initial begin
    int ovr_o0, ovr_e0, got0, waited;
    logic saw_busy, cleared;

    rst    = 1'b1;
    serial = 1'b1;
    rdy    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", o_out, 8'h00);
    chk("rst_valid", o_vld, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_flags", {o_perr, o_ferr, o_ovr}, 3'b000);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", {o_busy, e_busy}, 2'b00);

    // F7 with parity bit 0: correct for odd, wrong for even.
    send_frame(8'hF7, 1'b0, 1'b1);
    chk("odd_out", o_out, 8'hF7);
    chk("odd_valid", o_vld, 1'b1);
    chk("odd_flags", {o_perr, o_ferr}, 2'b00);
    chk("even_out", e_out, 8'hF7);
    chk("even_perr", {e_perr, e_ferr}, 2'b10);
    accept();
    chk("handshake_clear", {o_vld, e_vld}, 2'b00);
    chk("handshake_hold", o_out, 8'hF7);

    // Framing error: 5A with stop bit 0, then line back high.
    send_frame(8'h5A, 1'b1, 1'b0);
    serial = 1'b1;
    chk("frame_out", o_out, 8'h5A);
    chk("frame_flags_odd", {o_vld, o_perr, o_ferr}, 3'b101);
    chk("frame_flags_even", {e_vld, e_perr, e_ferr}, 3'b111);
    repeat (4) @(negedge clk);
    accept();

    // Break: all-zero frame, line stays low; receiver must not restart.
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("break_out", o_out, 8'h00);
    chk("break_flags_odd", {o_vld, o_perr, o_ferr}, 3'b111);
    chk("break_flags_even", {e_vld, e_perr, e_ferr}, 3'b101);
    chk("break_no_rearm", {o_busy, e_busy}, 2'b00);
    serial = 1'b1;
    repeat (4) @(negedge clk);
    accept();

    // Glitch: 3-cycle low pulse must be rejected as a false start.
    serial = 1'b0;
    repeat (3) @(negedge clk);
    saw_busy = o_busy;
    serial = 1'b1;
    chk("glitch_detected", saw_busy, 1'b1);
    cleared = 1'b0;
    waited = 0;
    while (!cleared && waited < Os / 2 + 3) begin
      @(negedge clk);
      waited++;
      if (o_busy === 1'b0 && e_busy === 1'b0) cleared = 1'b1;
    end
    chk("glitch_busy_clear", cleared, 1'b1);
    repeat (20) @(negedge clk);
    chk("glitch_no_valid", {o_vld, e_vld}, 2'b00);

    // Back-to-back with no consumer: second frame dropped, one overrun pulse.
    ovr_o0 = ovr_o_n;
    ovr_e0 = ovr_e_n;
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hA3, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("ovr_out", o_out, 8'h55);
    chk("ovr_valid", {o_vld, e_vld}, 2'b11);
    chk("ovr_odd_pulses", ovr_o_n - ovr_o0, 1);
    chk("ovr_even_pulses", ovr_e_n - ovr_e0, 1);
    chk("ovr_not_sticky", {o_ovr, e_ovr}, 2'b00);
    accept();

    // Back-to-back with consumer ready: both delivered in order.
    rdy = 1'b1;
    repeat (2) @(negedge clk);
    got0 = got_n;
    ovr_o0 = ovr_o_n;
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hA3, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("b2b_count", got_n - got0, 2);
    if (got_n - got0 == 2) begin
      chk("b2b_first", got[got0], 8'h55);
      chk("b2b_second", got[got0+1], 8'hA3);
    end
    chk("b2b_no_ovr", ovr_o_n - ovr_o0, 0);
    chk("b2b_drained", o_vld, 1'b0);
    rdy = 1'b0;

    // Reset mid-frame with a word held.
    send_frame(8'h81, 1'b1, 1'b1);
    chk("pre_rst_held", {o_vld, o_out}, {1'b1, 8'h81});
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("pre_rst_busy", o_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {o_out, e_out}, 16'h0000);
    chk("mid_rst_state", {o_vld, o_busy, o_perr, o_ferr, o_ovr}, 5'b00000);
    serial = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b1);
    chk("post_rst_out", {o_out, e_out}, 16'h3C3C);
    chk("post_rst_odd", {o_vld, o_perr, o_ferr}, 3'b110);
    chk("post_rst_even", {e_vld, e_perr, e_ferr}, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
